// File: rtl/param_counter.sv
// param_counter: up/down modulo counter with a configurable width, a terminal
// value, an enable prescaler, a clamped synchronous load, a registered one-cycle
// terminal-count pulse and a sticky wrap flag.
//
// The count range is 0..LIMIT. Wrapping is done with explicit compares against
// LIMIT, so the counter wraps correctly even when LIMIT < 2**WIDTH-1.
// Parameter legality: 1 <= LIMIT <= 2**WIDTH-1 and PRESCALE >= 1.
module param_counter #(
  parameter int WIDTH    = 8,
  parameter int LIMIT    = 255,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  // The prescaler always has at least one bit. With PRESCALE=1 it stays at
  // zero, so every enabled cycle becomes a step.
  localparam int PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0]  LIMIT_V  = WIDTH'(LIMIT);

  logic [WIDTH-1:0]  count_q, count_d;
  logic [PCNT_W-1:0] pcnt_q,  pcnt_d;
  logic              tc_q,    tc_d;
  logic              ovf_q,   ovf_d;
  logic              wrap;

  // Next-state logic. Priority is load > en > idle; a wrap sets ovf even when
  // clr_ovf is asserted in the same cycle.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves
    // one unassigned and no latch is inferred; combinational logic uses blocking '='.
    count_d = count_q;
    pcnt_d  = pcnt_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    wrap    = 1'b0;

    if (clr_ovf) begin
      ovf_d = 1'b0;
    end

    if (load) begin
      // Out-of-range load values are clamped to the terminal value.
      count_d = (load_val > LIMIT_V) ? LIMIT_V : load_val;
      pcnt_d  = '0;
    end else if (en) begin
      if (pcnt_q != PCNT_MAX) begin
        pcnt_d = pcnt_q + PCNT_W'(1);
      end else begin
        pcnt_d = '0;
        if (dir) begin
          if (count_q < LIMIT_V) begin
            count_d = count_q + WIDTH'(1);
          end else begin
            count_d = '0;
            wrap    = 1'b1;
          end
        end else begin
          if (count_q > '0) begin
            count_d = count_q - WIDTH'(1);
          end else begin
            count_d = LIMIT_V;
            wrap    = 1'b1;
          end
        end
      end
    end

    if (wrap) begin
      tc_d  = 1'b1;
      ovf_d = 1'b1;
    end
  end

  // State registers with asynchronous active-high clear.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the values from before the edge, independent of statement order.
    if (rst) begin
      count_q <= '0;
      pcnt_q  <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      pcnt_q  <= pcnt_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_param_counter.sv
// Self-checking bench for param_counter. Three instances share one set of
// inputs, and each section checks only the instance whose parameters it targets:
//   u_a: WIDTH=4, LIMIT=9,   PRESCALE=1
//   u_b: WIDTH=4, LIMIT=9,   PRESCALE=3
//   u_c: WIDTH=8, LIMIT=100, PRESCALE=4
// Inputs change on the falling edge. Outputs are sampled 1 ns after the rising edge.
module tb_param_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       load;
  logic [7:0] load_val;
  logic       dir;
  logic       clr_ovf;

  logic [3:0] count_a, count_b;
  logic [7:0] count_c;
  logic       tc_a, tc_b, tc_c;
  logic       ovf_a, ovf_b, ovf_c;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  param_counter #(.WIDTH(4), .LIMIT(9), .PRESCALE(1)) u_a (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val[3:0]),
    .dir(dir), .clr_ovf(clr_ovf), .count(count_a), .tc(tc_a), .ovf(ovf_a)
  );

  param_counter #(.WIDTH(4), .LIMIT(9), .PRESCALE(3)) u_b (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val[3:0]),
    .dir(dir), .clr_ovf(clr_ovf), .count(count_b), .tc(tc_b), .ovf(ovf_b)
  );

  param_counter #(.WIDTH(8), .LIMIT(100), .PRESCALE(4)) u_c (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .dir(dir), .clr_ovf(clr_ovf), .count(count_c), .tc(tc_c), .ovf(ovf_c)
  );

  typedef struct {
    logic       load;
    logic [7:0] load_val;
    logic       en;
    logic       dir;
    logic       clr;
    logic [3:0] exp_count;
    logic       exp_tc;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_total++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  task automatic drive(input logic l, input logic [7:0] lv, input logic e,
                       input logic d, input logic c);
    @(negedge clk);
    load = l; load_val = lv; en = e; dir = d; clr_ovf = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; load = 1'b0; load_val = '0; en = 1'b0; dir = 1'b1; clr_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive one cycle of inputs and check instance c after the next edge.
  task automatic step_c(input string name, input logic e, input logic d,
                        input logic [7:0] exp_count, input logic exp_tc);
    drive(1'b0, 8'd0, e, d, 1'b0);
    tick();
    check({name, " count"}, count_c, exp_count);
    check({name, " tc"}, tc_c, exp_tc);
  endtask

  initial begin
    // Vectors for u_a (LIMIT=9, PRESCALE=1), applied from the reset state.
    //           load  val    en    dir   clr   cnt  tc    ovf
    vecs[0]  = '{1'b1, 8'd8,  1'b1, 1'b1, 1'b0, 4'd8, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'd0,  1'b1, 1'b1, 1'b0, 4'd9, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'd0,  1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 8'd0,  1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 8'd0,  1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 8'd0,  1'b0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 8'd15, 1'b0, 1'b1, 1'b0, 4'd9, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'd0,  1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 8'd9,  1'b0, 1'b1, 1'b0, 4'd9, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 8'd0,  1'b1, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 4'd9, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 4'd8, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 8'd3,  1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 8'd0,  1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 4'd9, 1'b1, 1'b1};

    rst = 1'b1; load = 1'b0; load_val = '0; en = 1'b0; dir = 1'b1; clr_ovf = 1'b0;
    #12;
    check("por count_a", count_a, 0);
    check("por tc_a", tc_a, 0);
    check("por ovf_a", ovf_a, 0);
    check("por count_c", count_c, 0);
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset mid-operation, then counting resumes from zero.
    drive(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
    repeat (5) tick();
    check("pre-reset count_a", count_a, 5);
    #3 rst = 1'b1;
    #1;
    check("async rst count_a", count_a, 0);
    check("async rst tc_a", tc_a, 0);
    check("async rst ovf_a", ovf_a, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("post-reset count_a[%0d]", i), count_a, i);
    end

    // Table-driven vectors for u_a.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].load, vecs[i].load_val, vecs[i].en, vecs[i].dir, vecs[i].clr);
      tick();
      check($sformatf("vec%0d count", i), count_a, vecs[i].exp_count);
      check($sformatf("vec%0d tc", i), tc_a, vecs[i].exp_tc);
      check($sformatf("vec%0d ovf", i), ovf_a, vecs[i].exp_ovf);
    end

    // u_b: load 1, then count down with PRESCALE=3 so each value holds 3 cycles.
    do_reset();
    drive(1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
    tick();
    check("b load count", count_b, 1);
    drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    begin
      logic [3:0] exp_b[9];
      logic       exp_tb[9];
      exp_b  = '{4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd9, 4'd9, 4'd9, 4'd8};
      exp_tb = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      for (int k = 0; k < 9; k++) begin
        tick();
        check($sformatf("b down count[%0d]", k), count_b, exp_b[k]);
        check($sformatf("b down tc[%0d]", k), tc_b, exp_tb[k]);
      end
    end
    check("b ovf after wrap", ovf_b, 1);

    // u_c: a clamped load with en=1 takes no step and clears the prescaler.
    do_reset();
    drive(1'b1, 8'd200, 1'b1, 1'b1, 1'b0);
    tick();
    check("c clamp count", count_c, 100);
    check("c clamp tc", tc_c, 0);
    step_c("c pre1", 1'b1, 1'b1, 8'd100, 1'b0);
    step_c("c pre2", 1'b1, 1'b1, 8'd100, 1'b0);
    step_c("c pre3", 1'b1, 1'b1, 8'd100, 1'b0);
    step_c("c wrap", 1'b1, 1'b1, 8'd0, 1'b1);
    check("c ovf", ovf_c, 1);

    // Both count and the prescaler freeze while en=0 (pcnt is at 2 on entry).
    step_c("c run1", 1'b1, 1'b1, 8'd0, 1'b0);
    step_c("c run2", 1'b1, 1'b1, 8'd0, 1'b0);
    for (int k = 0; k < 5; k++) step_c($sformatf("c hold%0d", k), 1'b0, 1'b1, 8'd0, 1'b0);
    step_c("c resume3", 1'b1, 1'b1, 8'd0, 1'b0);
    step_c("c step up", 1'b1, 1'b1, 8'd1, 1'b0);
    // A direction flip mid-prescale only takes effect at the next step.
    step_c("c p1", 1'b1, 1'b1, 8'd1, 1'b0);
    step_c("c flip p2", 1'b1, 1'b0, 8'd1, 1'b0);
    step_c("c flip p3", 1'b1, 1'b0, 8'd1, 1'b0);
    step_c("c step down", 1'b1, 1'b0, 8'd0, 1'b0);
    step_c("c d1", 1'b1, 1'b0, 8'd0, 1'b0);
    step_c("c d2", 1'b1, 1'b0, 8'd0, 1'b0);
    step_c("c d3", 1'b1, 1'b0, 8'd0, 1'b0);
    step_c("c down wrap", 1'b1, 1'b0, 8'd100, 1'b1);
    step_c("c after wrap", 1'b0, 1'b0, 8'd100, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
